// File: rtl/ls_pkg.sv
// Shared helpers for the ls_unit command scheduler.
//  bitwidth(x)  : bits needed to represent the value x (at least 1)
//  log2c(x)     : address bits for x entries (at least 1)
//  cmd_width()  : width of one packed FIFO command word
// Command word layout (MSB..LSB), called cmd_t throughout:
//  {store, vlr[bitwidth(MVL):0], addr[DEPTH-1:0], stride[bitwidth(MAX_STRIDE)-1:0],
//   indexed, mask[MVL-1:0], tag[TAG_W-1:0]}
package ls_pkg;

  function automatic int bitwidth(input int x);
    return (x <= 0) ? 1 : $clog2(x + 1);
  endfunction

  function automatic int log2c(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int cmd_width(input int depth, input int mvl,
                                   input int max_stride, input int tag_w);
    return 1 + (bitwidth(mvl) + 1) + depth + bitwidth(max_stride) + 1 + mvl + tag_w;
  endfunction

endpackage

// File: rtl/ls_cmd_fifo.sv
// Command FIFO, ENTRIES x WIDTH, head-of-queue visible combinationally.
//  clk, rst      : clock, synchronous active-low reset
//  push/push_data: write one entry (ignored when full)
//  pop           : drop the head entry (ignored when empty)
//  full, empty   : status from the registered count
//  head          : oldest entry
module ls_cmd_fifo
  import ls_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = log2c(ENTRIES);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(ENTRIES));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);  // ENTRIES is a power of 2: natural wrap
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ls_scheduler.sv
// In-order vector load/store scheduler in front of ls_unit.
//  req_*        : command from the issue stage (valid/ready handshake)
//  busy_write/busy_read : ls_unit port busy flags
//  write_signal/read_signal : one-cycle launch pulses (read one-hot)
//  VLR/address/stride/indexed/mask : config bus, head command during launch, else 0
//  done_w/done_r + tags : completion pulses on each port's busy falling edge
//  zero_drop    : a vlr==0 command was swallowed
//  idle         : nothing queued, pending or busy
// Handshake: a command transfers on a clock edge where req_valid && req_ready;
// req_ready depends only on registered FIFO state (no pop-bypass).
module ls_scheduler
  import ls_pkg::*;
#(
  parameter int DEPTH          = 10,
  parameter int MEM_READ_PORTS = 2,
  parameter int MVL            = 64,
  parameter int MAX_STRIDE     = 16,
  parameter int CMD_DEPTH      = 4,
  parameter int TAG_W          = 4,
  parameter int STRICT_ORDER   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_store,
  input  logic [bitwidth(MVL):0]            req_vlr,
  input  logic [DEPTH-1:0]                  req_addr,
  input  logic [bitwidth(MAX_STRIDE)-1:0]   req_stride,
  input  logic                              req_indexed,
  input  logic [MVL-1:0]                    req_mask,
  input  logic [TAG_W-1:0]                  req_tag,
  input  logic                              busy_write,
  input  logic [MEM_READ_PORTS-1:0]         busy_read,
  output logic                              write_signal,
  output logic [MEM_READ_PORTS-1:0]         read_signal,
  output logic [bitwidth(MVL):0]            VLR,
  output logic [DEPTH-1:0]                  address,
  output logic [bitwidth(MAX_STRIDE)-1:0]   stride,
  output logic                              indexed,
  output logic [MVL-1:0]                    mask,
  output logic                              done_w,
  output logic [TAG_W-1:0]                  done_w_tag,
  output logic [MEM_READ_PORTS-1:0]         done_r,
  output logic [TAG_W*MEM_READ_PORTS-1:0]   done_r_tag,
  output logic                              zero_drop,
  output logic                              idle
);
  localparam int NP    = MEM_READ_PORTS;
  localparam int VLR_W = bitwidth(MVL) + 1;
  localparam int STR_W = bitwidth(MAX_STRIDE);
  localparam int CMD_W = cmd_width(DEPTH, MVL, MAX_STRIDE, TAG_W);
  localparam logic [VLR_W-1:0] MVL_V = VLR_W'(MVL);

  // FIFO interface
  logic             fifo_full, fifo_empty, accept, push, pop;
  logic [CMD_W-1:0] push_data, head;
  logic [VLR_W-1:0] vlr_clamped;

  // head command fields
  logic             h_store, h_indexed;
  logic [VLR_W-1:0] h_vlr;
  logic [DEPTH-1:0] h_addr;
  logic [STR_W-1:0] h_stride;
  logic [MVL-1:0]   h_mask;
  logic [TAG_W-1:0] h_tag;

  // state
  logic                       pend_w_q, pend_w_d, busy_w_q, busy_w_d;
  logic [NP-1:0]              pend_r_q, pend_r_d, busy_r_q, busy_r_d;
  logic [TAG_W-1:0]           tag_w_q, tag_w_d;
  logic [NP-1:0][TAG_W-1:0]   tag_r_q, tag_r_d;
  logic                       zero_drop_q, zero_drop_d;

  // launch decision
  logic          eb_w, launch_w, launch_any, found;
  logic [NP-1:0] eb_r, launch_r;

  assign req_ready   = !fifo_full;
  assign accept      = rst && req_valid && req_ready;
  // vlr==0 would hang ls_unit, so it is acknowledged but never queued
  assign push        = accept && (req_vlr != '0);
  assign vlr_clamped = (req_vlr > MVL_V) ? MVL_V : req_vlr;
  assign push_data   = {req_store, vlr_clamped, req_addr, req_stride, req_indexed, req_mask, req_tag};
  assign {h_store, h_vlr, h_addr, h_stride, h_indexed, h_mask, h_tag} = head;

  ls_cmd_fifo #(.WIDTH(CMD_W), .ENTRIES(CMD_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  // Busy is taken from its registered copy so launch depends only on flops:
  // a port is released the cycle after its done pulse. pend covers the gap
  // between a launch and ls_unit raising busy.
  assign eb_w = busy_w_q | pend_w_q;
  assign eb_r = busy_r_q | pend_r_q;

  always_comb begin
    launch_w = 1'b0;
    launch_r = '0;
    found    = 1'b0;
    if (rst && !fifo_empty) begin
      if (h_store) begin
        if (!eb_w && (STRICT_ORDER == 0 || eb_r == '0)) launch_w = 1'b1;
      end else if (STRICT_ORDER == 0 || !eb_w) begin
        for (int p = 0; p < NP; p++) begin
          if (!found && !eb_r[p]) begin
            launch_r[p] = 1'b1;
            found       = 1'b1;
          end
        end
      end
    end
  end

  assign launch_any = launch_w | (|launch_r);
  assign pop        = launch_any;

  always_comb begin
    pend_w_d    = launch_w ? 1'b1 : (busy_write ? 1'b0 : pend_w_q);
    tag_w_d     = launch_w ? h_tag : tag_w_q;
    busy_w_d    = busy_write;
    busy_r_d    = busy_read;
    zero_drop_d = accept && (req_vlr == '0);
    pend_r_d    = pend_r_q;
    tag_r_d     = tag_r_q;
    for (int p = 0; p < NP; p++) begin
      if (launch_r[p]) begin
        pend_r_d[p] = 1'b1;
        tag_r_d[p]  = h_tag;
      end else if (busy_read[p]) begin
        pend_r_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_w_q    <= 1'b0;
      pend_r_q    <= '0;
      busy_w_q    <= 1'b0;
      busy_r_q    <= '0;
      tag_w_q     <= '0;
      tag_r_q     <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      pend_w_q    <= pend_w_d;
      pend_r_q    <= pend_r_d;
      busy_w_q    <= busy_w_d;
      busy_r_q    <= busy_r_d;
      tag_w_q     <= tag_w_d;
      tag_r_q     <= tag_r_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  // Outputs. Pulses are masked while rst is low so a reset that lands on an
  // active command produces no stray launch or done.
  always_comb begin
    write_signal = launch_w;
    read_signal  = launch_r;
    VLR          = launch_any ? h_vlr     : '0;
    address      = launch_any ? h_addr    : '0;
    stride       = launch_any ? h_stride  : '0;
    indexed      = launch_any ? h_indexed : 1'b0;
    mask         = launch_any ? h_mask    : '0;
    done_w       = rst && busy_w_q && !busy_write;
    done_w_tag   = done_w ? tag_w_q : '0;
    done_r       = '0;
    done_r_tag   = '0;
    for (int p = 0; p < NP; p++) begin
      done_r[p] = rst && busy_r_q[p] && !busy_read[p];
      if (done_r[p]) done_r_tag[p*TAG_W +: TAG_W] = tag_r_q[p];
    end
    zero_drop = rst && zero_drop_q;
    idle      = fifo_empty && !(|busy_read) && !busy_write && !(|pend_r_q) && !pend_w_q;
  end

endmodule

// File: tb/tb_ls_scheduler.sv
`timescale 1ns/1ps
module tb_ls_scheduler;
  localparam int TAG_W = 4;
  localparam int LW    = 1 + 2 + 8 + 10 + 5 + 1 + 64;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0, req_indexed = 1'b0;
  logic [7:0]  req_vlr = '0;
  logic [9:0]  req_addr = '0;
  logic [4:0]  req_stride = '0;
  logic [63:0] req_mask = '0;
  logic [3:0]  req_tag = '0;
  logic        busy_write;
  logic [1:0]  busy_read;
  logic        write_signal, indexed, done_w, zero_drop, idle;
  logic [1:0]  read_signal, done_r;
  logic [7:0]  VLR;
  logic [9:0]  address;
  logic [4:0]  stride;
  logic [63:0] mask;
  logic [3:0]  done_w_tag;
  logic [7:0]  done_r_tag;

  ls_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_vlr(req_vlr), .req_addr(req_addr),
    .req_stride(req_stride), .req_indexed(req_indexed), .req_mask(req_mask),
    .req_tag(req_tag), .busy_write(busy_write), .busy_read(busy_read),
    .write_signal(write_signal), .read_signal(read_signal), .VLR(VLR),
    .address(address), .stride(stride), .indexed(indexed), .mask(mask),
    .done_w(done_w), .done_w_tag(done_w_tag), .done_r(done_r),
    .done_r_tag(done_r_tag), .zero_drop(zero_drop), .idle(idle)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0, bad = 0;
  logic [LW-1:0]    exp_q[$];        // expected launches, in order
  logic [TAG_W-1:0] exp_dw_q[$];
  logic [TAG_W-1:0] exp_dr0_q[$];
  logic [TAG_W-1:0] exp_dr1_q[$];
  int launch_log[$];
  int dw_cyc = -1, dr0_cyc = -1;
  int zd_exp = 0, zd_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // ---------------- ls_unit model: busy for VLR cycles after launch ----------------
  int   cnt_w = 0;
  int   cnt_r0 = 0, cnt_r1 = 0;
  logic act_w = 1'b0;
  logic [1:0] act_r = 2'b00;
  assign busy_write = act_w;
  assign busy_read  = act_r;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (write_signal)   cnt_w  = int'(VLR);
      if (read_signal[0]) cnt_r0 = int'(VLR);
      if (read_signal[1]) cnt_r1 = int'(VLR);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      cnt_w = 0; cnt_r0 = 0; cnt_r1 = 0;
      act_w = 1'b0; act_r = 2'b00;
    end else begin
      act_w    = (cnt_w > 0);  if (cnt_w > 0)  cnt_w--;
      act_r[0] = (cnt_r0 > 0); if (cnt_r0 > 0) cnt_r0--;
      act_r[1] = (cnt_r1 > 0); if (cnt_r1 > 0) cnt_r1--;
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (write_signal || (read_signal != 2'b00)) begin
      launch_log.push_back(cyc);
      if (exp_q.size() == 0) unexpected("launch");
      else check("launch", {write_signal, read_signal, VLR, address, stride, indexed, mask},
                 exp_q.pop_front());
    end
    if (done_w) begin
      dw_cyc = cyc;
      if (exp_dw_q.size() == 0) unexpected("done_w");
      else check("done_w_tag", done_w_tag, exp_dw_q.pop_front());
    end
    if (done_r[0]) begin
      dr0_cyc = cyc;
      if (exp_dr0_q.size() == 0) unexpected("done_r0");
      else check("done_r0_tag", done_r_tag[3:0], exp_dr0_q.pop_front());
    end
    if (done_r[1]) begin
      if (exp_dr1_q.size() == 0) unexpected("done_r1");
      else check("done_r1_tag", done_r_tag[7:4], exp_dr1_q.pop_front());
    end
    if (zero_drop) zd_seen++;
  end

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic send(input logic st, input int vlr, input int addr, input int str,
                      input logic idx, input logic [63:0] msk, input int tag,
                      input int port, input logic exp_done);
    int n;
    int evl;
    logic [1:0] rs;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #2; n++;
    end
    if (!req_ready) unexpected("send_ready_timeout");
    req_valid   = 1'b1;
    req_store   = st;
    req_vlr     = 8'(vlr);
    req_addr    = 10'(addr);
    req_stride  = 5'(str);
    req_indexed = idx;
    req_mask    = msk;
    req_tag     = 4'(tag);
    if (vlr == 0) begin
      zd_exp++;
    end else begin
      evl = (vlr > 64) ? 64 : vlr;
      rs  = st ? 2'b00 : ((port == 1) ? 2'b10 : 2'b01);
      exp_q.push_back({st, rs, 8'(evl), 10'(addr), 5'(str), idx, msk});
      if (exp_done) begin
        if (st)             exp_dw_q.push_back(4'(tag));
        else if (port == 1) exp_dr1_q.push_back(4'(tag));
        else                exp_dr0_q.push_back(4'(tag));
      end
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!idle && n < 300) begin
      @(negedge clk); n++;
    end
    check(name, idle, 1'b1);
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  int k;
  initial begin
    // reset
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_outs", {write_signal, read_signal, done_w, done_r, zero_drop, VLR, address}, '0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_outs", {write_signal, read_signal, done_w, done_r, zero_drop, VLR, mask}, '0);
    @(posedge clk); #2;

    // 1: single load, launch at N+1 on port 0
    send(1'b0, 4, 8, 1, 1'b0, 64'h0000_0000_0000_000F, 1, 0, 1'b1);
    @(negedge clk);
    check("t1_read_signal", read_signal, 2'b01);
    check("t1_address", address, 10'd8);
    check("t1_vlr", VLR, 8'd4);
    @(posedge clk); #2;
    wait_idle("t1_idle");

    // 2: two loads back-to-back on ports 0/1, third waits for port 0
    k = launch_log.size();
    send(1'b0, 4, 16, 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1'b1);
    send(1'b0, 4, 32, 3, 1'b1, 64'hAAAA_5555_AAAA_5555, 3, 1, 1'b1);
    send(1'b0, 2, 48, 4, 1'b0, 64'h0123_4567_89AB_CDEF, 4, 0, 1'b1);
    wait_idle("t2_idle");
    check("t2_consecutive", launch_log[k+1] - launch_log[k], 1);
    check("t2_third_stall", launch_log[k+2] - launch_log[k], 6);

    // 3: strict order, store waits for the in-flight load
    k = launch_log.size();
    send(1'b0, 4, 100, 1, 1'b0, 64'h0000_FFFF_0000_FFFF, 5, 0, 1'b1);
    send(1'b1, 3, 200, 2, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 6, 0, 1'b1);
    wait_idle("t3_idle");
    check("t3_store_after_done", launch_log[k+1] - dr0_cyc, 1);
    check("t3_store_latency", launch_log[k+1] - launch_log[k], 6);

    // 4: long store blocks loads, FIFO fills, ready returns after one launch
    send(1'b1, 64, 300, 5, 1'b1, 64'h8000_0000_0000_0001, 7, 0, 1'b1);
    send(1'b0, 2, 1,  1, 1'b0, 64'h1, 8,  0, 1'b1);
    send(1'b0, 2, 2,  1, 1'b0, 64'h2, 9,  1, 1'b1);
    send(1'b0, 2, 3,  1, 1'b0, 64'h3, 10, 0, 1'b1);
    send(1'b0, 2, 4,  1, 1'b0, 64'h4, 11, 1, 1'b1);
    check("t4_full_ready", req_ready, 1'b0);
    check("t4_full_idle", idle, 1'b0);
    k = 0;
    @(negedge clk);
    while (read_signal == 2'b00 && k < 200) begin
      @(negedge clk); k++;
    end
    check("t4_launch_after_done_w", cyc - dw_cyc, 1);
    check("t4_ready_in_launch", req_ready, 1'b0);
    @(negedge clk);
    check("t4_ready_after_launch", req_ready, 1'b1);
    @(posedge clk); #2;
    send(1'b0, 2, 1023, 16, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 12, 0, 1'b1);
    wait_idle("t4_idle");

    // 5: vlr==0 dropped, vlr>MVL clamped
    send(1'b0, 0, 7, 1, 1'b0, 64'hFF, 13, 0, 1'b1);
    @(negedge clk);
    check("t5_zero_drop", zero_drop, 1'b1);
    check("t5_zero_no_launch", read_signal, 2'b00);
    @(negedge clk);
    check("t5_zero_drop_pulse", zero_drop, 1'b0);
    check("t5_zero_idle", idle, 1'b1);
    @(posedge clk); #2;
    send(1'b0, 100, 5, 2, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 14, 0, 1'b1);
    @(negedge clk);
    check("t5_clamp_vlr", VLR, 8'd64);
    @(posedge clk); #2;
    wait_idle("t5_idle");

    // 6: reset during an active store, no done afterwards
    send(1'b1, 20, 77, 3, 1'b0, 64'h5, 15, 0, 1'b0);
    repeat (5) begin @(posedge clk); #2; end
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("t6_idle", idle, 1'b1);
    check("t6_ready", req_ready, 1'b1);
    check("t6_outs", {write_signal, read_signal, done_w, done_r, zero_drop, VLR, address}, '0);
    repeat (30) @(posedge clk);
    #2;

    // end-of-run bookkeeping
    check("end_launch_q", exp_q.size(), 0);
    check("end_dw_q", exp_dw_q.size(), 0);
    check("end_dr0_q", exp_dr0_q.size(), 0);
    check("end_dr1_q", exp_dr1_q.size(), 0);
    check("end_zero_drop_count", zd_seen, zd_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
